// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register and IF/ID pipeline register for the 16-bit core.
// Drives the fetch address, captures the instruction, and handles stall,
// branch/jump redirects and HALT freezing of fetch.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd4,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INST    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic [15:0] inst_in,
  output logic [15:0] pc,
  output logic [15:0] if_id_inst,
  output logic [15:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q, count_d;

  logic        redirect_s;
  logic [15:0] redirect_pc_s;
  logic [15:0] pc_next_s;

  // Redirect target selection: the EX branch is older than the ID jump, so it wins.
  always_comb begin
    redirect_s    = branch_taken | jump;
    redirect_pc_s = 16'h0000;
    if (branch_taken) begin
      redirect_pc_s = {branch_target[15:2], 2'b00};
    end else begin
      redirect_pc_s = {jump_target[15:2], 2'b00};
    end
    pc_next_s = pc_q + PC_STEP;
  end

  // Next-state logic: holds everything by default, then applies the per-state action.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
    case (state_q)
      BOOT: begin
        // One guaranteed bubble after reset: nothing is latched here.
        state_d = RUN;
      end
      RUN: begin
        if (redirect_s) begin
          pc_d    = redirect_pc_s;
          inst_d  = NOP_INST;
          pc4_d   = 16'h0000;
          valid_d = 1'b0;
        end else if (stall) begin
          // Hold pc, IF/ID and fetch_count.
          state_d = RUN;
        end else begin
          inst_d  = inst_in;
          pc4_d   = pc_next_s;
          valid_d = 1'b1;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
          if (inst_in[15:12] == HALT_OPCODE) begin
            // HALT is delivered but the pc is frozen on its own address.
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d = pc_next_s;
          end
        end
      end
      HALTED: begin
        inst_d  = NOP_INST;
        pc4_d   = 16'h0000;
        valid_d = 1'b0;
        if (redirect_s) begin
          // A resolving older branch/jump cancels the speculative HALT.
          pc_d     = redirect_pc_s;
          halted_d = 1'b0;
          state_d  = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      pc4_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_inst     = inst_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan scenarios with literal
// expectations, then randomized stimulus checked against a behavioural model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] inst_in;
  logic [15:0] pc;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:16383];

  int n_cmp;
  int n_err;
  bit chk_en;

  // model state: what the outputs must be
  logic [15:0] m_pc, m_inst, m_pc4, m_count;
  logic        m_valid, m_halted, m_boot;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .inst_in(inst_in),
    .pc(pc), .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  assign inst_in = mem[pc[15:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_inst = 16'h0000; m_pc4 = 16'h0000; m_count = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
  endtask

  // Outcome of one rising edge, derived from the rules directly.
  task automatic model_step();
    logic [15:0] t, w;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (branch_taken || jump) begin
      t = branch_taken ? branch_target : jump_target;
      m_pc = t & 16'hFFFC;
      m_inst = 16'h0000; m_pc4 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_inst = 16'h0000; m_pc4 = 16'h0000; m_valid = 1'b0;
    end else if (!stall) begin
      w = mem[m_pc >> 2];
      m_inst = w;
      m_pc4 = m_pc + 16'd4;
      m_valid = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (w[15:12] == 4'hF) m_halted = 1'b1;
      else m_pc = m_pc + 16'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  // Assert reset between edges and check outputs clear without a clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", {15'd0, if_id_valid}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_count", fetch_count, 16'h0000);
    check("rst_inst", if_id_inst, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("if_id_inst", if_id_inst, m_inst);
      check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      check("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
      check("halted", {15'd0, halted}, {15'd0, m_halted});
      check("fetch_count", fetch_count, m_count);
    end
  end

  initial begin
    logic [15:0] r;
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 16'h0000; jump_target = 16'h0000;
    model_reset();
    for (int i = 0; i < 16384; i++) begin
      r = 16'($urandom);
      if (r[15:12] == 4'hF && $urandom_range(0, 7) != 0) r[15] = 1'b0;
      mem[i] = r;
    end
    mem[0] = 16'h0400; mem[1] = 16'h0441; mem[2] = 16'h2050; mem[3] = 16'h1280;
    mem[4] = 16'h0123; mem[5] = 16'hF000; mem[8] = 16'h3123; mem[16383] = 16'h1234;

    chk_en = 1'b1;
    repeat (2) cyc();
    check("reset_pc", pc, 16'h0000);
    check("reset_count", fetch_count, 16'h0000);
    rst_n = 1'b1;
    // boot bubble then sequential fetch
    cyc();
    check("boot_valid", {15'd0, if_id_valid}, 16'h0000);
    check("boot_pc", pc, 16'h0000);
    cyc();
    check("f1_inst", if_id_inst, 16'h0400);
    check("f1_pc4", if_id_pc_plus4, 16'h0004);
    cyc();
    check("f2_inst", if_id_inst, 16'h0441);
    // stall for three cycles at pc=8
    stall = 1'b1;
    repeat (3) cyc();
    check("stall_pc", pc, 16'h0008);
    check("stall_inst", if_id_inst, 16'h0441);
    check("stall_pc4", if_id_pc_plus4, 16'h0008);
    check("stall_count", fetch_count, 16'h0002);
    stall = 1'b0;
    cyc();
    check("f3_inst", if_id_inst, 16'h2050);
    cyc();
    check("f4_inst", if_id_inst, 16'h1280);
    check("f4_count", fetch_count, 16'h0004);
    check("f4_pc", pc, 16'h0010);
    // branch + jump + stall together
    branch_taken = 1'b1; branch_target = 16'h0022;
    jump = 1'b1; jump_target = 16'h0040; stall = 1'b1;
    cyc();
    check("redir_pc", pc, 16'h0020);
    check("redir_valid", {15'd0, if_id_valid}, 16'h0000);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    cyc();
    check("tgt_inst", if_id_inst, 16'h3123);
    check("tgt_pc4", if_id_pc_plus4, 16'h0024);
    // HALT at pc=20
    jump = 1'b1; jump_target = 16'h0014;
    cyc();
    jump = 1'b0;
    cyc();
    check("halt_inst", if_id_inst, 16'hF000);
    check("halt_valid", {15'd0, if_id_valid}, 16'h0001);
    check("halt_pc", pc, 16'h0014);
    check("halt_flag", {15'd0, halted}, 16'h0001);
    check("halt_count", fetch_count, 16'h0006);
    stall = 1'b1;
    cyc();
    check("halted_bubble", {15'd0, if_id_valid}, 16'h0000);
    check("halted_pc", pc, 16'h0014);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 16'h0008;
    cyc();
    check("unhalt_flag", {15'd0, halted}, 16'h0000);
    check("unhalt_pc", pc, 16'h0008);
    branch_taken = 1'b0;
    cyc();
    check("resume_inst", if_id_inst, 16'h2050);
    // wrap at 16'hFFFC (target low bits masked)
    jump = 1'b1; jump_target = 16'hFFFE;
    cyc();
    check("wrap_jpc", pc, 16'hFFFC);
    jump = 1'b0;
    cyc();
    check("wrap_pc4", if_id_pc_plus4, 16'h0000);
    check("wrap_pc", pc, 16'h0000);
    check("wrap_inst", if_id_inst, 16'h1234);
    // async reset mid-stall
    stall = 1'b1;
    cyc();
    async_reset();
    stall = 1'b0;
    cyc();
    check("reboot_valid", {15'd0, if_id_valid}, 16'h0000);
    cyc();
    check("refetch_inst", if_id_inst, 16'h0400);
    // async reset mid-halt
    jump = 1'b1; jump_target = 16'h0014;
    cyc();
    jump = 1'b0;
    repeat (2) cyc();
    check("pre_rst_halted", {15'd0, halted}, 16'h0001);
    async_reset();
    repeat (2) cyc();

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      jump = ($urandom_range(0, 11) == 0);
      branch_target = 16'($urandom);
      jump_target = 16'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
